// File: rtl/cpu_port_bridge.sv
// CPU-side port bridge: writable output latches, synchronised input channels with
// sticky change flags, a masked interrupt and a delayed reset for the CPU core.
module cpu_port_bridge #(
  parameter int WIDTH       = 8,
  parameter int NCH         = 2,
  parameter int SYNC_STAGES = 2,
  parameter int RST_STAGES  = 2,
  localparam int SW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 CLK,
  input  logic                 nRESET,
  output logic                 nRESET_CPU,
  input  logic                 LOOPBACK,
  input  logic                 WE,
  input  logic [SW-1:0]        WSEL,
  input  logic [WIDTH-1:0]     WDATA,
  input  logic                 MASK_WE,
  input  logic [NCH-1:0]       MASK_IN,
  input  logic                 RD_EN,
  input  logic [SW-1:0]        RSEL,
  output logic [WIDTH-1:0]     RDATA,
  output logic                 RVALID,
  output logic [NCH*WIDTH-1:0] OUT,
  input  logic [NCH*WIDTH-1:0] EXT_IN,
  output logic [NCH-1:0]       CHG,
  output logic                 IRQ
);

  logic [RST_STAGES-1:0]  rst_sr;
  logic [NCH*WIDTH-1:0]   sync_q [SYNC_STAGES];
  logic [NCH*WIDTH-1:0]   src;
  logic [NCH*WIDTH-1:0]   in_sync;
  logic [NCH*WIDTH-1:0]   prev;
  logic [NCH-1:0]         diff;
  logic [NCH-1:0]         mask;
  logic [WIDTH-1:0]       rd_mux;

  // Release chain: a 1 walks in from bit 0, the CPU leaves reset when it reaches the top.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      rst_sr <= '0;
    end else begin
      rst_sr[0] <= 1'b1;
      for (int i = 1; i < RST_STAGES; i++) rst_sr[i] <= rst_sr[i-1];
    end
  end

  assign nRESET_CPU = rst_sr[RST_STAGES-1];

  // Selecting before the synchroniser keeps loopback and external latency identical.
  assign src     = LOOPBACK ? OUT : EXT_IN;
  assign in_sync = sync_q[SYNC_STAGES-1];
  assign IRQ     = |(CHG & mask);

  always_comb begin
    diff   = '0;
    rd_mux = '0;
    for (int c = 0; c < NCH; c++) begin
      diff[c] = (in_sync[c*WIDTH +: WIDTH] != prev[c*WIDTH +: WIDTH]);
      if (int'(RSEL) == c) rd_mux = in_sync[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      OUT    <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev   <= '0;
      CHG    <= '0;
      mask   <= '0;
      RDATA  <= '0;
      RVALID <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (WE && int'(WSEL) == c) OUT[c*WIDTH +: WIDTH] <= WDATA;
        // Set wins over a clearing read in the same cycle.
        if (diff[c])                        CHG[c] <= 1'b1;
        else if (RD_EN && int'(RSEL) == c)  CHG[c] <= 1'b0;
      end
      sync_q[0] <= src;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev <= in_sync;
      if (MASK_WE) mask <= MASK_IN;
      RVALID <= RD_EN;
      if (RD_EN) RDATA <= rd_mux;
    end
  end

endmodule

// File: tb/tb_cpu_port_bridge.sv
// Directed bench for cpu_port_bridge: a default 2-channel instance plus a 3-channel
// instance whose wider select lets out-of-range write/read indices be driven.
module tb_cpu_port_bridge;

  logic        clk;
  logic        n_reset;

  // Main instance (WIDTH=8, NCH=2)
  logic        nrst_cpu, loopback, we, wsel, mask_we, rd_en, rsel, rvalid, irq;
  logic [7:0]  wdata, rdata;
  logic [1:0]  mask_in, chg;
  logic [15:0] out_bus, ext_in;

  // Auxiliary instance (WIDTH=8, NCH=3)
  logic        a_nrst_cpu, a_loopback, a_we, a_mask_we, a_rd_en, a_rvalid, a_irq;
  logic [1:0]  a_wsel, a_rsel;
  logic [7:0]  a_wdata, a_rdata;
  logic [2:0]  a_mask_in, a_chg;
  logic [23:0] a_out, a_ext_in;

  int tests = 0;
  int fails = 0;

  cpu_port_bridge #(.WIDTH(8), .NCH(2), .SYNC_STAGES(2), .RST_STAGES(2)) u_dut (
    .CLK(clk), .nRESET(n_reset), .nRESET_CPU(nrst_cpu), .LOOPBACK(loopback),
    .WE(we), .WSEL(wsel), .WDATA(wdata), .MASK_WE(mask_we), .MASK_IN(mask_in),
    .RD_EN(rd_en), .RSEL(rsel), .RDATA(rdata), .RVALID(rvalid), .OUT(out_bus),
    .EXT_IN(ext_in), .CHG(chg), .IRQ(irq)
  );

  cpu_port_bridge #(.WIDTH(8), .NCH(3), .SYNC_STAGES(2), .RST_STAGES(2)) u_aux (
    .CLK(clk), .nRESET(n_reset), .nRESET_CPU(a_nrst_cpu), .LOOPBACK(a_loopback),
    .WE(a_we), .WSEL(a_wsel), .WDATA(a_wdata), .MASK_WE(a_mask_we), .MASK_IN(a_mask_in),
    .RD_EN(a_rd_en), .RSEL(a_rsel), .RDATA(a_rdata), .RVALID(a_rvalid), .OUT(a_out),
    .EXT_IN(a_ext_in), .CHG(a_chg), .IRQ(a_irq)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [7:0] d);
    we = 1'b1; wsel = sel; wdata = d;
  endtask

  task automatic rd(input logic sel);
    rd_en = 1'b1; rsel = sel;
  endtask

  task automatic idle();
    we = 1'b0; rd_en = 1'b0; mask_we = 1'b0;
  endtask

  initial begin
    n_reset = 1'b0;
    loopback = 1'b0; we = 1'b1; wsel = 1'b1; wdata = 8'hFF;
    mask_we = 1'b1; mask_in = 2'b11; rd_en = 1'b1; rsel = 1'b0; ext_in = 16'hFFFF;
    a_loopback = 1'b0; a_we = 1'b0; a_wsel = '0; a_wdata = '0; a_mask_we = 1'b0;
    a_mask_in = '0; a_rd_en = 1'b0; a_rsel = '0; a_ext_in = '0;

    // Reset holds every output low even with active strobes.
    #3;
    chk("rst_out", out_bus, 16'h0);
    chk("rst_nrst_cpu", nrst_cpu, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    tick();
    chk("rst_out_edge", out_bus, 16'h0);
    chk("rst_chg_edge", chg, 2'b00);
    chk("rst_rdata_edge", rdata, 8'h00);
    chk("rst_rvalid_edge", rvalid, 1'b0);
    chk("rst_irq_edge", irq, 1'b0);
    idle(); ext_in = 16'h0000;
    tick();
    n_reset = 1'b1;
    tick();
    chk("nrst_cpu_edge0", nrst_cpu, 1'b0);
    tick();
    chk("nrst_cpu_edge1", nrst_cpu, 1'b1);
    chk("chg_after_rst", chg, 2'b00);

    // Loopback write 0xA5 to channel 1.
    loopback = 1'b1;
    wr(1'b1, 8'hA5);
    tick();                                  // edge k
    idle();
    chk("lb_out_k", out_bus, 16'hA500);
    chk("lb_chg_k", chg, 2'b00);
    tick();                                  // k+1
    tick();                                  // k+2
    chk("lb_chg_k2", chg, 2'b00);
    tick();                                  // k+3
    chk("lb_chg_k3", chg, 2'b10);
    rd(1'b1);
    tick();
    idle();
    chk("lb_rdata", rdata, 8'hA5);
    chk("lb_rvalid", rvalid, 1'b1);
    chk("lb_chg_clr", chg, 2'b00);
    tick();
    chk("lb_rvalid_drop", rvalid, 1'b0);
    chk("lb_rdata_hold", rdata, 8'hA5);

    // External path with mask 01; keep ch1 matching the latch so the switch is silent.
    ext_in = 16'hA500;
    loopback = 1'b0;
    mask_we = 1'b1; mask_in = 2'b01;
    tick();
    idle();
    tick();
    tick();
    chk("ext_switch_silent", chg, 2'b00);
    ext_in = 16'hA53C;
    tick();
    tick();
    chk("ext0_chg_e2", chg, 2'b00);
    chk("ext0_irq_e2", irq, 1'b0);
    tick();
    chk("ext0_chg_e3", chg, 2'b01);
    chk("ext0_irq_e3", irq, 1'b1);
    rd(1'b0);
    tick();
    idle();
    chk("ext0_rdata", rdata, 8'h3C);
    chk("ext0_chg_clr", chg, 2'b00);
    chk("ext0_irq_clr", irq, 1'b0);
    ext_in = 16'h773C;
    tick(); tick(); tick();
    chk("ext1_chg", chg, 2'b10);
    chk("ext1_irq_masked", irq, 1'b0);
    rd(1'b1);
    tick();
    idle();
    chk("ext1_rdata", rdata, 8'h77);
    chk("ext1_chg_clr", chg, 2'b00);

    // Clearing read on the edge where CHG[0] sets: the set wins.
    ext_in = 16'h77C3;
    tick(); tick();
    rd(1'b0);
    tick();
    idle();
    chk("race_chg", chg, 2'b01);
    chk("race_rdata", rdata, 8'hC3);
    chk("race_rvalid", rvalid, 1'b1);
    chk("race_irq", irq, 1'b1);
    tick();
    chk("race_rdata_hold", rdata, 8'hC3);
    chk("race_chg_hold", chg, 2'b01);
    rd(1'b0);
    tick();
    idle();
    chk("race_chg_clr", chg, 2'b00);

    // Toggle loopback: both channels differ between latch and external value.
    loopback = 1'b1;
    tick(); tick();
    chk("tog_chg_e2", chg, 2'b00);
    tick();
    chk("tog_chg_e3", chg, 2'b11);
    rd(1'b0); wr(1'b0, 8'h5A);
    tick();                                  // write edge j
    chk("b2b_rdata0", rdata, 8'h00);
    chk("b2b_chg0", chg, 2'b10);
    chk("b2b_out0", out_bus, 16'hA55A);
    rd(1'b1); wr(1'b1, 8'h5A);
    tick();                                  // j+1
    idle();
    chk("b2b_rdata1", rdata, 8'hA5);
    chk("b2b_rvalid1", rvalid, 1'b1);
    chk("b2b_chg1", chg, 2'b00);
    chk("b2b_out1", out_bus, 16'h5A5A);
    tick();                                  // j+2
    chk("b2b_chg_j2", chg, 2'b00);
    tick();                                  // j+3
    chk("b2b_chg_j3", chg, 2'b01);
    tick();                                  // j+4
    chk("b2b_chg_j4", chg, 2'b11);

    // Reset pulsed during a pending read.
    rd(1'b0);
    #2 n_reset = 1'b0;
    #1;
    chk("mid_rst_out", out_bus, 16'h0);
    chk("mid_rst_chg", chg, 2'b00);
    chk("mid_rst_rvalid", rvalid, 1'b0);
    chk("mid_rst_nrst_cpu", nrst_cpu, 1'b0);
    chk("mid_rst_irq", irq, 1'b0);
    tick();
    chk("mid_rst_rvalid_edge", rvalid, 1'b0);
    chk("mid_rst_rdata_edge", rdata, 8'h00);
    idle();
    loopback = 1'b0;
    n_reset = 1'b1;
    tick();
    chk("re_nrst_cpu_e0", nrst_cpu, 1'b0);
    tick();
    chk("re_nrst_cpu_e1", nrst_cpu, 1'b1);
    chk("re_chg_e2", chg, 2'b00);
    tick();
    chk("re_ext_chg", chg, 2'b11);

    // Out-of-range indices on the 3-channel instance.
    a_loopback = 1'b1;
    a_we = 1'b1; a_wsel = 2'd2; a_wdata = 8'h81;
    tick();                                  // edge m
    chk("oor_out_valid_wr", a_out, 24'h810000);
    a_wsel = 2'd3; a_wdata = 8'hFF;
    tick();                                  // m+1
    a_we = 1'b0;
    chk("oor_out_ignored", a_out, 24'h810000);
    tick();                                  // m+2
    tick();                                  // m+3
    chk("oor_chg_set", a_chg, 3'b100);
    a_rd_en = 1'b1; a_rsel = 2'd3;
    tick();
    chk("oor_rdata", a_rdata, 8'h00);
    chk("oor_rvalid", a_rvalid, 1'b1);
    chk("oor_chg_kept", a_chg, 3'b100);
    a_rsel = 2'd2;
    tick();
    a_rd_en = 1'b0;
    chk("oor_rd2_rdata", a_rdata, 8'h81);
    chk("oor_rd2_chg", a_chg, 3'b000);
    tick();
    chk("oor_rvalid_drop", a_rvalid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
